// File: rtl/axi_slave_r.sv
// AXI4 read-channel responder: one AR at a time, ARLEN+1 R beats whose data is a
// fixed function of the byte address. Supports FIXED/INCR/WRAP, narrow sizes and SLVERR.
module axi_slave_r #(
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 32,
  parameter int MEM_BYTES = 8192
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               S_AXI_ARVALID,
  output logic               S_AXI_ARREADY,
  input  logic [1:0]         S_AXI_ARBURST,
  input  logic [2:0]         S_AXI_ARSIZE,
  input  logic [ADDR_WD-1:0] S_AXI_ARADDR,
  input  logic [7:0]         S_AXI_ARLEN,
  output logic               S_AXI_RVALID,
  input  logic               S_AXI_RREADY,
  output logic               S_AXI_RLAST,
  output logic [DATA_WD-1:0] S_AXI_RDATA,
  output logic [1:0]         S_AXI_RRESP
);

  localparam int DATA_BYTES = DATA_WD / 8;
  localparam int SIZE_MAX   = $clog2(DATA_BYTES);
  localparam logic [ADDR_WD-1:0] ONE       = ADDR_WD'(1);
  localparam logic [ADDR_WD-1:0] MEM_LIMIT = ADDR_WD'(MEM_BYTES);
  localparam logic [7:0]         LANE_MASK = ~8'(DATA_BYTES - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_reg;
  logic                 arready_reg, rvalid_reg, rlast_reg, err_reg;
  logic [DATA_WD-1:0]   rdata_reg;
  logic [1:0]           rresp_reg, burst_reg;
  logic [2:0]           size_reg;
  logic [7:0]           len_reg, cnt_reg;
  logic [ADDR_WD-1:0]   addr_reg;

  // Address of the beat following addr under the given burst rules.
  function automatic logic [ADDR_WD-1:0] next_addr(
    input logic [ADDR_WD-1:0] addr,
    input logic [2:0]         size,
    input logic [1:0]         burst,
    input logic [7:0]         len
  );
    logic [ADDR_WD-1:0] s, w, base, nxt;
    s    = ONE << size;
    w    = (ADDR_WD'(len) + ONE) << size;
    base = addr & ~(w - ONE);
    nxt  = (addr & ~(s - ONE)) + s;
    case (burst)
      2'b00: nxt = addr;
      2'b10: begin
        nxt = addr + s;
        if (nxt == base + w) nxt = base;
      end
      default: ;
    endcase
    return nxt;
  endfunction

  logic               ar_illegal;
  logic [ADDR_WD-1:0] ar_size_mask;
  logic [ADDR_WD-1:0] ld_addr;
  logic               ld_err, ld_bad;
  logic [7:0]         ld_lo;
  logic [DATA_WD-1:0] ld_lanes, ld_data;
  logic [1:0]         ld_resp;

  assign ar_size_mask = (ONE << S_AXI_ARSIZE) - ONE;
  assign ar_illegal   = (S_AXI_ARSIZE > 3'(SIZE_MAX))
                     || (S_AXI_ARBURST == 2'b11)
                     || ((S_AXI_ARBURST == 2'b10) &&
                         !(S_AXI_ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15}))
                     || ((S_AXI_ARBURST == 2'b10) &&
                         ((S_AXI_ARADDR & ar_size_mask) != '0));

  // The beat being loaded into the output registers: first beat on accept, else the next one.
  assign ld_addr = (state_reg == IDLE) ? S_AXI_ARADDR
                                       : next_addr(addr_reg, size_reg, burst_reg, len_reg);
  assign ld_err  = (state_reg == IDLE) ? ar_illegal : err_reg;
  assign ld_bad  = ld_err || (ld_addr >= MEM_LIMIT);
  assign ld_lo   = ld_addr[7:0] & LANE_MASK;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      assign ld_lanes[gi*8 +: 8] = ld_lo + 8'(gi);
    end
  endgenerate

  assign ld_data = ld_bad ? '0 : ld_lanes;
  assign ld_resp = ld_bad ? 2'b10 : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= 2'b00;
      err_reg     <= 1'b0;
      burst_reg   <= 2'b00;
      size_reg    <= 3'd0;
      len_reg     <= 8'd0;
      cnt_reg     <= 8'd0;
      addr_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          arready_reg <= 1'b1;
          if (S_AXI_ARVALID && arready_reg) begin
            state_reg   <= BURST;
            arready_reg <= 1'b0;
            burst_reg   <= S_AXI_ARBURST;
            size_reg    <= S_AXI_ARSIZE;
            len_reg     <= S_AXI_ARLEN;
            addr_reg    <= S_AXI_ARADDR;
            err_reg     <= ar_illegal;
            cnt_reg     <= 8'd0;
            rvalid_reg  <= 1'b1;
            rlast_reg   <= (S_AXI_ARLEN == 8'd0);
            rdata_reg   <= ld_data;
            rresp_reg   <= ld_resp;
          end
        end
        BURST: begin
          if (rvalid_reg && S_AXI_RREADY) begin
            if (rlast_reg) begin
              state_reg   <= IDLE;
              arready_reg <= 1'b1;
              rvalid_reg  <= 1'b0;
              rlast_reg   <= 1'b0;
              rdata_reg   <= '0;
              rresp_reg   <= 2'b00;
            end else begin
              addr_reg  <= ld_addr;
              cnt_reg   <= cnt_reg + 8'd1;
              rlast_reg <= ((cnt_reg + 8'd1) == len_reg);
              rdata_reg <= ld_data;
              rresp_reg <= ld_resp;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RLAST   = rlast_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = rresp_reg;

endmodule

// File: tb/tb_axi_slave_r.sv
// Bench for axi_slave_r: directed and random bursts checked beat-by-beat against an
// address-arithmetic reference model, with random RREADY stalls and a mid-burst reset.
module tb_axi_slave_r;

  localparam int ADDR_WD   = 32;
  localparam int DATA_WD   = 32;
  localparam int MEM_BYTES = 8192;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                S_AXI_ARVALID, S_AXI_ARREADY;
  logic [1:0]          S_AXI_ARBURST;
  logic [2:0]          S_AXI_ARSIZE;
  logic [ADDR_WD-1:0]  S_AXI_ARADDR;
  logic [7:0]          S_AXI_ARLEN;
  logic                S_AXI_RVALID, S_AXI_RREADY, S_AXI_RLAST;
  logic [DATA_WD-1:0]  S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;

  int tests = 0;
  int fails = 0;

  axi_slave_r #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARSIZE(S_AXI_ARSIZE),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: whole-burst legality, beat address, data and response.
  function automatic bit model_illegal(input logic [1:0] b, input logic [2:0] sz,
                                       input logic [31:0] a, input logic [7:0] ln);
    longint unsigned s = longint'(1) << sz;
    if (sz > 3'd2) return 1'b1;
    if (b == 2'b11) return 1'b1;
    if (b == 2'b10 && !(ln == 1 || ln == 3 || ln == 7 || ln == 15)) return 1'b1;
    if (b == 2'b10 && (longint'(a) % s) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_addr(input logic [1:0] b, input logic [2:0] sz,
                                             input logic [31:0] a, input logic [7:0] ln,
                                             input int i);
    longint unsigned s = longint'(1) << sz;
    longint unsigned st = longint'(a);
    longint unsigned w, base;
    if (b == 2'b00) return a;
    if (b == 2'b10) begin
      w    = (longint'(ln) + 1) * s;
      base = (st / w) * w;
      return 32'(base + ((st - base + longint'(i) * s) % w));
    end
    if (i == 0) return a;
    return 32'((st / s) * s + longint'(i) * s);
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] ba);
    logic [31:0] d = '0;
    longint unsigned al = (longint'(ba) / 4) * 4;
    for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'((al + longint'(k)) % 256);
    return d;
  endfunction

  task automatic do_burst(input logic [1:0] b, input logic [2:0] sz, input logic [31:0] a,
                          input logic [7:0] ln, input int rdy_pct, input int rst_beat);
    int i, cyc;
    bit ill, bad, hs;
    logic [31:0] ba;
    cyc = 0;
    while (S_AXI_ARREADY !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_val("arready_wait", 64'(S_AXI_ARREADY), 64'd1);
    S_AXI_ARVALID = 1'b1;
    S_AXI_ARBURST = b;
    S_AXI_ARSIZE  = sz;
    S_AXI_ARADDR  = a;
    S_AXI_ARLEN   = ln;
    @(negedge clk);
    S_AXI_ARVALID = 1'b0;
    check_val("rvalid_latency", 64'(S_AXI_RVALID), 64'd1);
    ill = model_illegal(b, sz, a, ln);
    i   = 0;
    cyc = 0;
    while (i <= int'(ln) && cyc < 500) begin
      ba  = model_addr(b, sz, a, ln, i);
      bad = ill || (ba >= 32'(MEM_BYTES));
      check_val("rvalid", 64'(S_AXI_RVALID), 64'd1);
      check_val("arready_busy", 64'(S_AXI_ARREADY), 64'd0);
      check_val("rdata", 64'(S_AXI_RDATA), bad ? 64'd0 : 64'(model_data(ba)));
      check_val("rresp", 64'(S_AXI_RRESP), bad ? 64'd2 : 64'd0);
      check_val("rlast", 64'(S_AXI_RLAST), 64'(i == int'(ln)));
      if (i == rst_beat) begin
        rst_n = 1'b0;
        S_AXI_RREADY = 1'b0;
        @(negedge clk);
        check_val("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
        check_val("rst_rlast", 64'(S_AXI_RLAST), 64'd0);
        check_val("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_arready", 64'(S_AXI_ARREADY), 64'd1);
        check_val("post_rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
        $display("[TB] burst=%0d size=%0d addr=%08h len=%0d reset at beat %0d", b, sz, a, ln, i);
        return;
      end
      S_AXI_RREADY = ($urandom_range(99) < 32'(rdy_pct));
      hs = S_AXI_RREADY && S_AXI_RVALID;
      @(negedge clk);
      cyc++;
      if (hs) i++;
    end
    check_val("beat_count", 64'(i), 64'(int'(ln) + 1));
    S_AXI_RREADY = 1'b0;
    check_val("end_rvalid", 64'(S_AXI_RVALID), 64'd0);
    check_val("end_arready", 64'(S_AXI_ARREADY), 64'd1);
    $display("[TB] burst=%0d size=%0d addr=%08h len=%0d beats=%0d cycles=%0d",
             b, sz, a, ln, i, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] b;
    logic [2:0] sz;
    logic [31:0] a;
    logic [7:0] ln;
    int r;
    rst_n = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_ARBURST = 2'b01;
    S_AXI_ARSIZE  = 3'd2;
    S_AXI_ARADDR  = '0;
    S_AXI_ARLEN   = '0;
    S_AXI_RREADY  = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_arready", 64'(S_AXI_ARREADY), 64'd0);
    check_val("reset_rvalid", 64'(S_AXI_RVALID), 64'd0);
    check_val("reset_rlast", 64'(S_AXI_RLAST), 64'd0);
    check_val("reset_rdata", 64'(S_AXI_RDATA), 64'd0);
    check_val("reset_rresp", 64'(S_AXI_RRESP), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("first_arready", 64'(S_AXI_ARREADY), 64'd1);

    do_burst(2'b01, 3'd2, 32'h0,    8'd3,  100, -1);
    do_burst(2'b10, 3'd2, 32'h8,    8'd3,  100, -1);
    do_burst(2'b10, 3'd2, 32'h8,    8'd2,  100, -1);
    do_burst(2'b00, 3'd2, 32'h10,   8'd3,  100, -1);
    do_burst(2'b01, 3'd0, 32'h1,    8'd4,  100, -1);
    do_burst(2'b01, 3'd2, 32'h40,   8'd15, 50,  -1);
    do_burst(2'b01, 3'd2, 32'h1FF8, 8'd3,  100, -1);
    do_burst(2'b01, 3'd3, 32'h0,    8'd1,  100, -1);
    do_burst(2'b01, 3'd2, 32'h100,  8'd0,  100, -1);
    do_burst(2'b01, 3'd2, 32'h20,   8'd7,  100, 2);
    do_burst(2'b01, 3'd2, 32'h0,    8'd1,  100, -1);

    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(9);
      b  = (r < 3) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      sz = ($urandom_range(9) == 0) ? 3'd3 : 3'($urandom_range(2));
      case ($urandom_range(6))
        0: ln = 8'd0;
        1: ln = 8'd1;
        2: ln = 8'd3;
        3: ln = 8'd7;
        4: ln = 8'd15;
        5: ln = 8'd2;
        default: ln = 8'($urandom_range(20));
      endcase
      a = ($urandom_range(3) == 0) ? 32'(MEM_BYTES - 1 - int'($urandom_range(63)))
                                   : 32'($urandom_range(MEM_BYTES - 1));
      if (b == 2'b10 && $urandom_range(3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      do_burst(b, sz, a, ln, 40 + int'($urandom_range(60)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
